// File: rtl/pixel_kernel_scheduler.sv
// pixel_kernel_scheduler
//   Runs one acquisition pass over a small kernel of pixel FSMs. Each enabled
//   pixel is started in ascending index order. The scheduler then waits for
//   that pixel's done, or for a programmable timeout, before it moves on.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start_in_path    pass request, in-path mode (wins over out-path)
//   start_out_path   pass request, out-path mode
//   enable_mask      pixels taking part, sampled at pass start
//   timeout_limit    max WAIT cycles per pixel (0 = none), sampled at pass start
//   err_clr          clears all sticky timeout flags
//   pxl_done_i       per-pixel done; only the pixel being served is looked at
//   pxl_start_o      one-hot, one-cycle start pulse
//   pxl_idx          index of the pixel being served
//   mode             0 = in-path, 1 = out-path, latched at pass start
//   busy             high whenever the FSM is outside IDLE
//   kernel_done      one-cycle pulse at the end of a pass
//   timeout_err      sticky per-pixel timeout flags
//
// Build option
//   PXL_SCHED_RETRY_EN  a pixel's first timeout in a pass re-issues its start
//                       once; the error flag is raised only if the retry also
//                       times out.

// Per-pixel slice: start pulse decode and sticky timeout flag.
module pixel_kernel_scheduler_lane (
  input  logic clk,
  input  logic rst,
  input  logic sel,      // this lane is the one being served
  input  logic issue,    // FSM is in ISSUE
  input  logic set_err,  // timeout on the served pixel this cycle
  input  logic err_clr,
  output logic start_o,
  output logic err
);
  assign start_o = issue & sel;

  // A new timeout takes precedence over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst)                err <= 1'b0;
    else if (set_err & sel) err <= 1'b1;
    else if (err_clr)       err <= 1'b0;
  end
endmodule

module pixel_kernel_scheduler #(
  parameter int NPIX      = 4,
  parameter int TIMEOUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in_path,
  input  logic                    start_out_path,
  input  logic [NPIX-1:0]         enable_mask,
  input  logic [TIMEOUT_W-1:0]    timeout_limit,
  input  logic                    err_clr,
  input  logic [NPIX-1:0]         pxl_done_i,
  output logic [NPIX-1:0]         pxl_start_o,
  output logic [$clog2(NPIX)-1:0] pxl_idx,
  output logic                    mode,
  output logic                    busy,
  output logic                    kernel_done,
  output logic [NPIX-1:0]         timeout_err
);
  localparam int IDX_W = $clog2(NPIX);
  localparam logic [TIMEOUT_W:0] CNT_ONE = (TIMEOUT_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [NPIX-1:0]      mask_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] cnt;
  logic [IDX_W-1:0]     first_idx, next_idx;
  logic                 first_vld, next_vld;
  logic                 start_req, cur_done, timeout_hit, set_err;
`ifdef PXL_SCHED_RETRY_EN
  logic                 retried;   // current pixel already had its retry
  logic                 retry;
`endif

  assign start_req = start_in_path | start_out_path;
  assign cur_done  = pxl_done_i[pxl_idx];
  // Fires in the WAIT cycle that completes limit_q cycles of waiting.
  assign timeout_hit = (limit_q != '0) &&
                       (({1'b0, cnt} + CNT_ONE) == {1'b0, limit_q});

  // Lowest enabled index of the live mask (pass start) and lowest latched
  // index above the current one (advance). Descending scan so the lowest
  // match is written last.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int i = NPIX-1; i >= 0; i--) begin
      if (enable_mask[i]) begin
        first_vld = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (mask_q[i] && (i > int'(pxl_idx))) begin
        next_vld = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
`ifdef PXL_SCHED_RETRY_EN
    retry     = 1'b0;
`endif
    case (state)
      S_IDLE:  if (start_req) state_nxt = first_vld ? S_ISSUE : S_DONE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // done has priority over a coincident timeout
        if (cur_done) begin
          state_nxt = S_NEXT;
        end else if (timeout_hit) begin
`ifdef PXL_SCHED_RETRY_EN
          if (!retried) begin
            retry     = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            set_err   = 1'b1;
            state_nxt = S_NEXT;
          end
`else
          set_err   = 1'b1;
          state_nxt = S_NEXT;
`endif
        end
      end
      S_NEXT:  state_nxt = next_vld ? S_ISSUE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_idx <= '0;
      mode    <= 1'b0;
      mask_q  <= '0;
      limit_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_req) begin
          mode    <= ~start_in_path;
          mask_q  <= enable_mask;
          limit_q <= timeout_limit;
          pxl_idx <= first_idx;
        end
        S_ISSUE: cnt <= '0;
        S_WAIT:  cnt <= cnt + TIMEOUT_W'(1);
        S_NEXT:  if (next_vld) pxl_idx <= next_idx;
        default: ;
      endcase
    end
  end

`ifdef PXL_SCHED_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst)                              retried <= 1'b0;
    else if (retry)                       retried <= 1'b1;
    else if (state == S_NEXT || state == S_IDLE) retried <= 1'b0;
  end
`endif

  assign busy        = (state != S_IDLE);
  assign kernel_done = (state == S_DONE);

  for (genvar i = 0; i < NPIX; i++) begin : g_lane
    pixel_kernel_scheduler_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel     (pxl_idx == IDX_W'(i)),
      .issue   (state == S_ISSUE),
      .set_err (set_err),
      .err_clr (err_clr),
      .start_o (pxl_start_o[i]),
      .err     (timeout_err[i])
    );
  end
endmodule

// File: tb/tb_pixel_kernel_scheduler.sv
// Self-checking bench for pixel_kernel_scheduler (NPIX=4, TIMEOUT_W=12).
// A responder models the pixel FSMs: each pixel returns done a programmed
// number of cycles after its start pulse (0 = never). Expected start indices
// go into a queue when a pass is launched and are popped as pulses appear.
module tb_pixel_kernel_scheduler;
  localparam int NPIX = 4;
  localparam int TW   = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_in_path, start_out_path, err_clr;
  logic [NPIX-1:0] enable_mask, pxl_done_i, pxl_start_o, timeout_err;
  logic [TW-1:0]   timeout_limit;
  logic [1:0]      pxl_idx;
  logic            mode, busy, kernel_done;

  pixel_kernel_scheduler #(.NPIX(NPIX), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .start_in_path(start_in_path), .start_out_path(start_out_path),
    .enable_mask(enable_mask), .timeout_limit(timeout_limit),
    .err_clr(err_clr), .pxl_done_i(pxl_done_i),
    .pxl_start_o(pxl_start_o), .pxl_idx(pxl_idx), .mode(mode),
    .busy(busy), .kernel_done(kernel_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            in_p;
    logic            out_p;
    logic            glitch;   // pulse start_out_path mid-pass
    logic [3:0]      mask;
    logic [TW-1:0]   limit;
    logic [3:0][7:0] dly;      // {px3,px2,px1,px0}, 0 = never done
    logic [3:0]      exp_err;
    logic            exp_mode;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];
  int dly_cfg [NPIX];
  int done_at [NPIX];
  int n_starts = 0;
  int done_cnt = 0;
  bit prev_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    pxl_done_i = '0;
    for (int i = 0; i < NPIX; i++) pxl_done_i[i] = (done_at[i] == cyc);
  end

  // Start-pulse monitor and pixel responder.
  always @(negedge clk) begin
    int idx;
    if (pxl_start_o != '0) begin
      idx = 0;
      for (int i = 0; i < NPIX; i++) if (pxl_start_o[i]) idx = i;
      chk("start_onehot", $countones(pxl_start_o), 1);
      chk("start_width", {31'd0, prev_start}, 0);
      n_starts++;
      if (exp_q.size() == 0) chk("unexpected_start", idx, 32'hFFFF);
      else chk("start_idx", idx, exp_q.pop_front());
      done_at[idx] = (dly_cfg[idx] != 0) ? cyc + dly_cfg[idx] : -1;
    end
    prev_start = (pxl_start_o != '0);
    if (kernel_done) done_cnt++;
  end

  function automatic int pass_len(input vec_t v);
    int n, d, l, w;
    n = 1;
    l = int'(v.limit);
    for (int i = 0; i < NPIX; i++) begin
      if (v.mask[i]) begin
        d = int'(v.dly[i]);
        if (d != 0 && (l == 0 || d <= l)) w = d;
        else begin
`ifdef PXL_SCHED_RETRY_EN
          w = 2*l + 1;
`else
          w = l;
`endif
        end
        n += 2 + w;
      end
    end
    return n;
  endfunction

  task automatic push_starts(input vec_t v);
    for (int i = 0; i < NPIX; i++) begin
      if (v.mask[i]) begin
        exp_q.push_back(i);
`ifdef PXL_SCHED_RETRY_EN
        if (v.limit != 0 && (v.dly[i] == 0 || int'(v.dly[i]) > int'(v.limit)))
          exp_q.push_back(i);
`endif
      end
    end
  endtask

  task automatic clear_errs();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);
  endtask

  task automatic run_pass(input vec_t v, input int id);
    int t0, got, base_done;
    for (int i = 0; i < NPIX; i++) dly_cfg[i] = int'(v.dly[i]);
    push_starts(v);
    base_done = done_cnt;
    @(negedge clk);
    enable_mask = v.mask; timeout_limit = v.limit;
    start_in_path = v.in_p; start_out_path = v.out_p;
    t0 = cyc;
    @(negedge clk);
    start_in_path = 1'b0; start_out_path = 1'b0;
    enable_mask = 4'hF; timeout_limit = 12'd1;   // must not matter mid-pass
    got = -1;
    for (int k = 0; k < 600; k++) begin
      if (kernel_done) begin got = cyc; break; end
      if (v.glitch && k == 3) start_out_path = 1'b1;
      if (k == 4) start_out_path = 1'b0;
      @(negedge clk);
    end
    start_out_path = 1'b0;
    chk($sformatf("v%0d_kdone_cycle", id), got - t0, pass_len(v));
    chk($sformatf("v%0d_mode", id), {31'd0, mode}, {31'd0, v.exp_mode});
    chk($sformatf("v%0d_timeout_err", id), timeout_err, v.exp_err);
    repeat (10) @(negedge clk);
    chk($sformatf("v%0d_one_kdone", id), done_cnt - base_done, 1);
    chk($sformatf("v%0d_idle", id), {31'd0, busy}, 0);
    chk($sformatf("v%0d_starts_left", id), exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t tbl [6];

  initial begin
    vec_t v;
    int base, base_done;
    //                  in out gl mask    limit  {px3,px2,px1,px0}          err     mode
    tbl[0] = '{1'b1, 1'b1, 1'b1, 4'b1111, 12'd0, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b1010, 12'd8, {8'd0, 8'd0, 8'd3, 8'd0}, 4'b1000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b0110, 12'd6, {8'd0, 8'd7, 8'd6, 8'd0}, 4'b0100, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 4'b0001, 12'd1, {8'd0, 8'd0, 8'd0, 8'd1}, 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 12'd5, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'b1001, 12'd3, {8'd2, 8'd0, 8'd0, 8'd0}, 4'b0001, 1'b0};

    for (int i = 0; i < NPIX; i++) begin dly_cfg[i] = 0; done_at[i] = -1; end
    rst = 1'b1; start_in_path = 0; start_out_path = 0; err_clr = 0;
    enable_mask = '0; timeout_limit = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", pxl_start_o, 0);
    chk("rst_idx", pxl_idx, 0);
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kdone", kernel_done, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;

    for (int n = 0; n < 6; n++) begin
      if (n != 0) clear_errs();
      run_pass(tbl[n], n);
    end

    // Reset in WAIT of idx 2 after an out-path pass start; error from the
    // last vector is still pending so its reset is visible.
    v = '{1'b0, 1'b1, 1'b0, 4'b0111, 12'd0, {8'd0, 8'd0, 8'd2, 8'd2}, 4'b0000, 1'b1};
    for (int i = 0; i < NPIX; i++) dly_cfg[i] = int'(v.dly[i]);
    push_starts(v);
    base = n_starts;
    base_done = done_cnt;
    @(negedge clk);
    enable_mask = v.mask; timeout_limit = v.limit; start_out_path = 1'b1;
    @(negedge clk);
    start_out_path = 1'b0;
    for (int k = 0; k < 200 && n_starts < base + 3; k++) @(negedge clk);
    chk("rst_case_reached_idx2", pxl_idx, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start", pxl_start_o, 0);
    chk("midrst_idx", pxl_idx, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_kdone", kernel_done, 0);
    chk("midrst_err", timeout_err, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_kdone", done_cnt - base_done, 0);
    chk("midrst_starts_left", exp_q.size(), 0);
    exp_q.delete();

    v = '{1'b1, 1'b0, 1'b0, 4'b0110, 12'd0, {8'd0, 8'd3, 8'd3, 8'd0}, 4'b0000, 1'b0};
    run_pass(v, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
